// File: rtl/drum_pkg.sv
// Shared types and width helpers for the DRUM approximate divider.
package drum_pkg;

    typedef enum logic [2:0] {IDLE, NORM, DIV, SHIFT, OUT} state_e;

    function automatic int unsigned cnt_width(input int unsigned k);
        return (2 * k > 1) ? $clog2(2 * k) : 1;
    endfunction

    // Signed width able to hold p - q_s - K for any operand widths.
    function automatic int unsigned sh_width(input int unsigned n, input int unsigned m);
        return $clog2((n > m) ? n : m) + 2;
    endfunction

endpackage

// File: rtl/drum_lod_trunc.sv
// Leading-one detect plus unbiased dynamic-range truncation of one operand to K bits.
module drum_lod_trunc #(
    parameter int unsigned W = 16,
    parameter int unsigned K = 6,
    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]    x,
    output logic [K-1:0]    x_t,
    output logic [IdxW-1:0] s_x
);

    logic [IdxW-1:0] lead;

    always_comb begin
        lead = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) lead = IdxW'(i);
        end
        if (lead > IdxW'(K - 1)) begin
            s_x = lead - IdxW'(K - 1);
            // Leading one lands on bit K-1; LSB forced high to centre the dropped range.
            x_t = K'(x >> s_x) | {{(K - 1){1'b0}}, 1'b1};
        end else begin
            s_x = '0;
            x_t = x[K-1:0];
        end
    end

endmodule

// File: rtl/drum_div_seq.sv
// Sequential DRUM approximate divider: truncate, 2K-step restoring divide, rescale.
module drum_div_seq
    import drum_pkg::*;
#(
    parameter int unsigned K = 6,
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         div_zero
);

    localparam int unsigned CntW  = cnt_width(K);
    localparam int unsigned ShW   = sh_width(N, M);
    localparam int unsigned QW    = 2 * K;
    localparam int unsigned WideW = N + QW;
    localparam int unsigned AIdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BIdxW = (M > 1) ? $clog2(M) : 1;

    state_e                state_q, state_d;
    logic [N-1:0]          a_q, a_d;
    logic [M-1:0]          b_q, b_d;
    logic [K-1:0]          bt_q, bt_d;
    logic signed [ShW-1:0] sh_q, sh_d;
    logic [K-1:0]          rem_q, rem_d;
    logic [QW-1:0]         dvd_q, dvd_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]          q_q, q_d;
    logic                  dz_q, dz_d;

    logic [K-1:0]     a_t, b_t;
    logic [AIdxW-1:0] s_a;
    logic [BIdxW-1:0] s_b;
    logic [K:0]       trial;
    logic [ShW-1:0]   sh_neg;
    logic [WideW-1:0] wide, shifted;

    drum_lod_trunc #(.W(N), .K(K)) u_trunc_a (.x(a_q), .x_t(a_t), .s_x(s_a));
    drum_lod_trunc #(.W(M), .K(K)) u_trunc_b (.x(b_q), .x_t(b_t), .s_x(s_b));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign q         = q_q;
    assign div_zero  = dz_q;

    always_comb begin
        wide    = {{(WideW - QW){1'b0}}, dvd_q};
        sh_neg  = -sh_q;
        shifted = sh_q[ShW-1] ? (wide >> sh_neg) : (wide << sh_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bt_d    = bt_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        dz_d    = dz_q;
        trial   = {rem_q, dvd_q[QW-1]};
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = NORM;
                end
            end
            NORM: begin
                bt_d = b_t;
                sh_d = ShW'(s_a) - ShW'(s_b) - ShW'(K);
                if (b_q == '0) begin
                    q_d     = '1;
                    dz_d    = 1'b1;
                    state_d = OUT;
                end else begin
                    rem_d   = '0;
                    dvd_d   = {a_t, {K{1'b0}}};
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                // Quotient bits shift into the dividend register as its MSBs are consumed.
                if (trial >= {1'b0, bt_q}) begin
                    rem_d = K'(trial - {1'b0, bt_q});
                    dvd_d = {dvd_q[QW-2:0], 1'b1};
                end else begin
                    rem_d = trial[K-1:0];
                    dvd_d = {dvd_q[QW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(QW - 1)) state_d = SHIFT;
            end
            SHIFT: begin
                q_d     = (|shifted[WideW-1:N]) ? '1 : shifted[N-1:0];
                dz_d    = 1'b0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bt_q    <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bt_q    <= bt_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_drum_div_seq.sv
// Self-checking bench for drum_div_seq against an arithmetic reference model.
module tb_drum_div_seq;

    localparam int K = 6;
    localparam int N = 16;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic         div_zero;

    int n_vec = 0;
    int n_err = 0;

    drum_div_seq #(.K(K), .N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DRUM truncation from the arithmetic definition.
    task automatic trunc(input longint x, output longint xt, output longint s);
        longint lead;
        lead = -1;
        for (int i = 0; i < 64; i++) if (((x >> i) & 1) == 1) lead = i;
        if (lead > K - 1) begin
            s  = lead - K + 1;
            xt = (x >> s) | 1;
        end else begin
            s  = 0;
            xt = x;
        end
    endtask

    task automatic model(input longint av, input longint bv, output longint mq, output bit mdz);
        longint at, sa, bt, sb, quot, sh, r;
        if (bv == 0) begin
            mq  = (longint'(1) << N) - 1;
            mdz = 1'b1;
            return;
        end
        trunc(av, at, sa);
        trunc(bv, bt, sb);
        quot = (at * (longint'(1) << K)) / bt;
        sh   = sa - sb - K;
        r    = (sh >= 0) ? (quot << sh) : (quot >> (-sh));
        if (r > (longint'(1) << N) - 1) r = (longint'(1) << N) - 1;
        mq  = r;
        mdz = 1'b0;
    endtask

    // One full transaction; result held for hold cycles before acceptance.
    task automatic run_op(input logic [N-1:0] av, input logic [M-1:0] bv,
                          input logic [N-1:0] exp_q, input bit exp_dz, input int hold,
                          input string name);
        int  lat, g, exp_lat;
        bit  busy_bad;
        g = 0;
        while (!in_ready && g < 50) begin
            step();
            g++;
        end
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = M'($urandom);
        lat      = 0;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            step();
            lat++;
        end
        exp_lat = exp_dz ? 1 : 2 * K + 2;
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges, want %0d (a=%0d b=%0d)", name, lat,
                     exp_lat, av, bv);
        end
        n_vec++;
        if (busy_bad !== 1'b0) begin
            n_err++;
            $display("FAIL %s in_ready while busy: got 1, want 0", name);
        end
        n_vec++;
        if (q !== exp_q) begin
            n_err++;
            $display("FAIL %s q: got %0d, want %0d (a=%0d b=%0d)", name, q, exp_q, av, bv);
        end
        n_vec++;
        if (div_zero !== exp_dz) begin
            n_err++;
            $display("FAIL %s div_zero: got %0b, want %0b", name, div_zero, exp_dz);
        end
        for (int i = 0; i < hold; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: got out_valid=%0b in_ready=%0b, want 0/1", name,
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, q, div_zero} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset state: got in_ready=%0b out_valid=%0b q=%0d dz=%0b, want 1/0/0/0",
                     in_ready, out_valid, q, div_zero);
        end
    endtask

    task automatic test_directed();
        run_op(16'd60, 16'd5, 16'd12, 1'b0, 0, "a60_b5");
        run_op(16'd100, 16'd10, 16'd10, 1'b0, 2, "a100_b10");
        run_op(16'd65535, 16'd1, 16'd64512, 1'b0, 0, "amax_b1");
        run_op(16'd0, 16'd7, 16'd0, 1'b0, 0, "a0_b7");
    endtask

    task automatic test_div_zero();
        run_op(16'd1234, 16'd0, 16'hFFFF, 1'b1, 0, "b0");
        run_op(16'd9, 16'd3, 16'd3, 1'b0, 0, "after_b0");
    endtask

    task automatic test_hold();
        logic [N-1:0] held;
        int           lat;
        bit           bad;
        a        = 16'd100;
        b        = 16'd10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        held     = q;
        bad      = 1'b0;
        in_valid = 1'b1;
        a        = 16'd7;
        b        = 16'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (q !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (bad !== 1'b0 || held !== 16'd10) begin
            n_err++;
            $display("FAIL hold: got q=%0d unstable=%0b, want q=10 stable", held, bad);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold release: got out_valid=%0b in_ready=%0b, want 0/1", out_valid,
                     in_ready);
        end
        // The ignored request must not have started a transaction.
        step();
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ignored request: got in_ready=%0b out_valid=%0b, want 1/0", in_ready,
                     out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        a        = 16'd60;
        b        = 16'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Acceptance, NORM, then DIV steps 0..4 leave the counter at 5.
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, q, div_zero} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL mid reset: got in_ready=%0b out_valid=%0b q=%0d dz=%0b, want 1/0/0/0",
                     in_ready, out_valid, q, div_zero);
        end
        run_op(16'd60, 16'd5, 16'd12, 1'b0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [N-1:0] av;
        logic [M-1:0] bv;
        longint       mq;
        bit           mdz;
        for (int i = 0; i < 40; i++) begin
            av = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 63)) : N'($urandom);
            case ($urandom_range(0, 5))
                0:       bv = '0;
                1, 2:    bv = M'($urandom_range(1, 63));
                default: bv = M'($urandom);
            endcase
            model(longint'(av), longint'(bv), mq, mdz);
            run_op(av, bv, N'(mq), mdz, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_hold();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
